uart_rx: RTL and testbench

- 8N1 asynchronous serial receiver; the receive end of the console's debug UART link, pairing with uart_tx.
- Samples the raw `rx` pin in the system clock domain and recovers bytes by mid-bit sampling.
- Presents each byte through a one-deep holding register with a valid/ready handshake.
- Lets the host or debug logic send commands to the console core over the same serial cable.

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-stream side of the 8N1 receiver: serial line in, held byte plus status out.
// master is the receiver, slave is the consumer that drives the line and ready.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  rx, rx_ready,
    output rx_data, rx_valid, frame_err, overrun, busy
  );

  modport slave (
    output rx, rx_ready,
    input  rx_data, rx_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-deep valid/ready holding register.
// Synchronous active-high reset; every output is driven straight from a flop.
module uart_rx #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.master bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx: CLK_HZ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            rx_meta_q;
  logic            rxs_q;
  logic            load_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            frame_err_q;
  logic            overrun_q;
  logic            busy_q;

  // Synchronizer, receive FSM and holding register in one clocked process.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      load_q      <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= bus.rx;
      rxs_q       <= rx_meta_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      load_q      <= 1'b0;

      // A good stop bit is committed one cycle after its sample point.
      if (load_q) begin
        if (!valid_q || bus.rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && bus.rx_ready) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_q;
      end

      case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= 3'd0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rxs_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rxs_q) begin
              load_q  <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // Line held low after a bad stop bit must not restart a frame.
        WAIT_IDLE: begin
          if (rxs_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT_IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; a byte scoreboard is checked
// whenever the receiver hands a byte over, and status pulses are counted.
module tb_uart_rx;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DIV    = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] sb[$];
  int         start_cyc = 0;
  int         rise_cyc = 0;
  int         n_rise = 0;
  int         n_acc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         rise_before;
  logic       valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; leaves the line at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    bus.rx    = 1'b0;
    start_cyc = cyc + 1;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      idle(DIV);
    end
    bus.rx = stop;
    idle(DIV);
  endtask

  // Output monitor: scoreboard pops on handshake, pulse and rise counters.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_valid && !valid_prev) begin
        n_rise++;
        rise_cyc = cyc;
      end
      valid_prev <= bus.rx_valid;
      if (bus.frame_err) fe_cnt++;
      if (bus.overrun) ov_cnt++;
      if (bus.rx_valid && bus.rx_ready) begin
        n_acc++;
        chk("sb_nonempty_at_pop", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) chk("rx_data_pop", 32'(bus.rx_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] b;
    bus.rx       = 1'b1;
    bus.rx_ready = 1'b1;
    reset        = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(bus.rx_valid), 32'd0);
    chk("reset_data", 32'(bus.rx_data), 32'd0);
    chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
    chk("reset_overrun", 32'(bus.overrun), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    idle(1);

    // Single byte with ready held high; latency from first low sample.
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(2 * DIV);
    chk("a5_latency", 32'(rise_cyc - start_cyc), 32'd98);
    chk("a5_sb_empty", 32'(sb.size()), 32'd0);
    chk("a5_accepts", 32'(n_acc), 32'd1);
    chk("a5_frame_err", 32'(fe_cnt), 32'd0);
    chk("a5_overrun", 32'(ov_cnt), 32'd0);

    // Back-to-back frames with a single stop bit.
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2 * DIV);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
    chk("b2b_accepts", 32'(n_acc), 32'd3);
    chk("b2b_flags", 32'(fe_cnt + ov_cnt), 32'd0);

    // Overrun: second byte dropped while first is unconsumed.
    bus.rx_ready = 1'b0;
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(2 * DIV);
    chk("ovr_valid_held", 32'(bus.rx_valid), 32'd1);
    chk("ovr_data_held", 32'(bus.rx_data), 32'h3C);
    chk("ovr_pulses", 32'(ov_cnt), 32'd1);
    chk("ovr_busy", 32'(bus.busy), 32'd0);
    bus.rx_ready = 1'b1;
    idle(1);
    chk("ovr_valid_drop", 32'(bus.rx_valid), 32'd0);
    chk("ovr_sb_empty", 32'(sb.size()), 32'd0);
    chk("ovr_accepts", 32'(n_acc), 32'd4);

    // Framing error followed by a held-low break.
    rise_before = n_rise;
    send_frame(8'h55, 1'b0);
    idle(30);
    chk("brk_busy_low_line", 32'(bus.busy), 32'd1);
    bus.rx = 1'b1;
    idle(5);
    chk("brk_busy_released", 32'(bus.busy), 32'd0);
    chk("brk_frame_err", 32'(fe_cnt), 32'd1);
    chk("brk_no_valid", 32'(n_rise), 32'(rise_before));
    chk("brk_overrun", 32'(ov_cnt), 32'd1);

    // Short low glitch must be rejected at the start-bit midpoint.
    rise_before = n_rise;
    bus.rx = 1'b0;
    idle(3);
    bus.rx = 1'b1;
    idle(2 * DIV);
    chk("glitch_busy", 32'(bus.busy), 32'd0);
    chk("glitch_no_valid", 32'(n_rise), 32'(rise_before));
    chk("glitch_flags", 32'(fe_cnt + ov_cnt), 32'd2);

    // Reset in the middle of the data bits, then a clean frame.
    b = 8'h81;
    bus.rx = 1'b0;
    idle(DIV);
    for (int i = 0; i < 4; i++) begin
      bus.rx = b[i];
      idle(DIV);
    end
    chk("mid_busy_before_reset", 32'(bus.busy), 32'd1);
    bus.rx = 1'b1;
    reset  = 1'b1;
    idle(1);
    reset  = 1'b0;
    chk("mid_reset_valid", 32'(bus.rx_valid), 32'd0);
    chk("mid_reset_data", 32'(bus.rx_data), 32'd0);
    chk("mid_reset_busy", 32'(bus.busy), 32'd0);
    chk("mid_reset_flags", 32'({bus.frame_err, bus.overrun}), 32'd0);
    idle(2 * DIV);
    rise_before = n_rise;
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(2 * DIV);
    chk("post_reset_sb_empty", 32'(sb.size()), 32'd0);
    chk("post_reset_rise", 32'(n_rise), 32'(rise_before + 1));
    chk("post_reset_data", 32'(bus.rx_data), 32'h81);
    chk("post_reset_flags", 32'(fe_cnt + ov_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
